mux_rr_pipe: RTL and testbench

//  Registered N-channel, W-bit multiplexer with per-channel valid/ready handshake.

---
 rtl/mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/mux_rr_pipe.sv | 93 +++++++++
 tb/tb_mux_rr_pipe.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered round-robin multiplexer.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index width for n items, never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first valid channel at or after ptr wins, wrapping at NCH.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NCH  = 3,
  localparam int SELW = clog2(NCH)
) (
  input  logic [NCH-1:0]  valid,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [SELW-1:0] idx,
  output logic            any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    // Upper segment [ptr, NCH-1] first, then the wrapped segment [0, ptr-1].
    for (int i = 0; i < NCH; i++) begin
      if (!any && valid[i] && (i >= int'(ptr))) begin
        any = 1'b1;
        idx = SELW'(i);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!any && valid[i] && (i < int'(ptr))) begin
        any = 1'b1;
        idx = SELW'(i);
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mux_rr_pipe.sv
// N-channel registered multiplexer with valid/ready handshake on every channel
// and on the output, selecting either a fixed channel or round-robin.
module mux_rr_pipe
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NCH   = 3,
  localparam int SELW  = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] IN_DATA,
  input  logic [NCH-1:0]       IN_VALID,
  output logic [NCH-1:0]       IN_READY,
  input  logic                 MODE,
  input  logic [SELW-1:0]      S,
  output logic [WIDTH-1:0]     Y,
  output logic                 Y_VALID,
  input  logic                 Y_READY,
  output logic [SELW-1:0]      Y_SEL
);

  logic [SELW-1:0]  ptr;
  logic [NCH-1:0]   rr_grant, fix_grant, g_onehot;
  logic [SELW-1:0]  rr_idx, fix_idx, g_idx;
  logic             rr_any, fix_any, g_any;
  logic             load;
  logic [WIDTH-1:0] g_data;

  rr_arbiter #(.NCH(NCH)) u_rr_arbiter (
    .valid (IN_VALID),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // An out-of-range S matches no channel, so it simply yields no grant.
  always_comb begin
    fix_grant = '0;
    fix_any   = 1'b0;
    fix_idx   = S;
    for (int i = 0; i < NCH; i++) begin
      if ((S == SELW'(i)) && IN_VALID[i]) begin
        fix_any      = 1'b1;
        fix_grant[i] = 1'b1;
      end
    end
  end

  always_comb begin
    if (MODE == MODE_RR) begin
      g_any    = rr_any;
      g_idx    = rr_idx;
      g_onehot = rr_grant;
    end else begin
      g_any    = fix_any;
      g_idx    = fix_idx;
      g_onehot = fix_grant;
    end
  end

  always_comb begin
    g_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (g_idx == SELW'(i)) g_data = IN_DATA[i*WIDTH +: WIDTH];
    end
  end

  // rst_n gates load so that no producer is told its word was taken while in reset.
  assign load     = rst_n && (!Y_VALID || Y_READY);
  assign IN_READY = (load && g_any) ? g_onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y       <= '0;
      Y_VALID <= 1'b0;
      Y_SEL   <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (g_any) begin
        Y       <= g_data;
        Y_SEL   <= g_idx;
        Y_VALID <= 1'b1;
        if (MODE == MODE_RR)
          ptr <= (int'(g_idx) == NCH - 1) ? '0 : g_idx + SELW'(1);
      end else begin
        Y_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Directed bench for mux_rr_pipe: default 3x32 instance plus a 5x8 instance.
module tb_mux_rr_pipe;

  logic clk;
  logic rst_n;

  logic [95:0] in_data;
  logic [2:0]  in_valid, in_ready;
  logic        mode, y_valid, y_ready;
  logic [1:0]  s, y_sel;
  logic [31:0] y;

  logic [39:0] d5_in_data;
  logic [4:0]  d5_in_valid, d5_in_ready;
  logic        d5_mode, d5_y_valid, d5_y_ready;
  logic [2:0]  d5_s, d5_y_sel;
  logic [7:0]  d5_y;

  int n_checks;
  int n_errors;

  mux_rr_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(in_ready), .MODE(mode), .S(s), .Y(y), .Y_VALID(y_valid),
    .Y_READY(y_ready), .Y_SEL(y_sel)
  );

  mux_rr_pipe #(.WIDTH(8), .NCH(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .IN_DATA(d5_in_data), .IN_VALID(d5_in_valid),
    .IN_READY(d5_in_ready), .MODE(d5_mode), .S(d5_s), .Y(d5_y), .Y_VALID(d5_y_valid),
    .Y_READY(d5_y_ready), .Y_SEL(d5_y_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rr_y   [4];
  logic [1:0]  rr_sel [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rr_y   = '{32'hA, 32'hB, 32'hC, 32'hA};
    rr_sel = '{2'd0, 2'd1, 2'd2, 2'd0};

    rst_n    = 1'b0;
    in_data  = {32'hC, 32'hB, 32'hA};
    in_valid = 3'b111;
    mode     = 1'b0;
    s        = 2'd0;
    y_ready  = 1'b1;
    d5_in_data  = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    d5_in_valid = 5'b00000;
    d5_mode     = 1'b0;
    d5_s        = 3'd0;
    d5_y_ready  = 1'b1;

    #12;
    chk("rst_y", y, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_sel", y_sel, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Fixed select
    in_valid = 3'b000;
    step();
    mode = 1'b0; s = 2'd1; in_valid = 3'b111;
    #1;
    chk("fix_in_ready", in_ready, 3'b010);
    step();
    chk("fix_y", y, 32'hB);
    chk("fix_y_sel", y_sel, 1);
    chk("fix_y_valid", y_valid, 1);
    s = 2'd2; in_valid = 3'b011;
    #1;
    chk("fix_nogrant_ready", in_ready, 0);
    step();
    chk("fix_nogrant_valid", y_valid, 0);
    chk("fix_nogrant_y_hold", y, 32'hB);
    chk("fix_nogrant_sel_hold", y_sel, 1);
    s = 2'd3; in_valid = 3'b111;
    #1;
    chk("fix_s_oob_ready", in_ready, 0);
    step();
    chk("fix_s_oob_valid", y_valid, 0);

    // Round-robin, pointer still 0 since fixed transfers never move it
    mode = 1'b1;
    #1;
    chk("rr_first_ready", in_ready, 3'b001);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_seq_y", y, rr_y[k]);
      chk("rr_seq_sel", y_sel, rr_sel[k]);
      chk("rr_seq_valid", y_valid, 1);
    end

    // Skip and wrap: move ptr to 2, then only ch0 valid
    in_valid = 3'b010;
    step();
    chk("rr_ch1_y", y, 32'hB);
    in_valid = 3'b001;
    #1;
    chk("rr_wrap_ready", in_ready, 3'b001);
    step();
    chk("rr_wrap_y", y, 32'hA);
    chk("rr_wrap_sel", y_sel, 0);
    in_valid = 3'b111;
    #1;
    chk("rr_ptr_after_wrap", in_ready, 3'b010);

    // Backpressure
    y_ready = 1'b0;
    #1;
    chk("bp_ready0", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_y_hold", y, 32'hA);
      chk("bp_sel_hold", y_sel, 0);
      chk("bp_valid_hold", y_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    y_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 3'b010);
    step();
    chk("bp_release_y", y, 32'hB);
    chk("bp_release_sel", y_sel, 1);

    // Asynchronous reset in mid-cycle
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_y", y, 0);
    chk("arst_y_valid", y_valid, 0);
    chk("arst_y_sel", y_sel, 0);
    chk("arst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_ptr_cleared", in_ready, 3'b001);

    // Five channel, eight bit instance
    d5_mode = 1'b1;
    d5_in_valid = 5'b11111;
    step();
    for (int k = 0; k < 6; k++) begin
      chk("p5_rr_sel", d5_y_sel, k % 5);
      chk("p5_rr_y", d5_y, 8'h10 + (k % 5));
      step();
    end
    d5_mode = 1'b0;
    d5_s = 3'd4;
    #1;
    chk("p5_fix4_ready", d5_in_ready, 5'b10000);
    d5_s = 3'd6;
    #1;
    chk("p5_s6_ready", d5_in_ready, 0);
    step();
    chk("p5_s6_valid", d5_y_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
